// File: rtl/mips_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pipe
// Brief    : MIPS32 5-stage control unit. Decodes ID, carries EX/MEM/WB control,
//            detects load-use/branch/MDU hazards. Optional MDU via MIPS_CTRL_MDU_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mips_ctrl_pipe #(
  parameter int ALUOP_W     = 5,
  parameter int MDU_LATENCY = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Func,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         id_rd,
  input  logic               Comp_EQ,
  output logic               id_stall,
  output logic [1:0]         PCSrcSel,
  output logic               SignExt,
  output logic               NextIsDelay,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_link,
  output logic [4:0]         ex_dst,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_byte,
  output logic               mem_half,
  output logic               mem_sign_ext,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [4:0]         wb_dst,
  output logic               mdu_busy
);

  localparam logic [ALUOP_W-1:0] c_aluAdd   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] c_aluAddu  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] c_aluSub   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] c_aluSubu  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] c_aluAnd   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] c_aluOr    = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] c_aluXor   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] c_aluNor   = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] c_aluSlt   = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] c_aluSltu  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] c_aluSll   = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] c_aluSrl   = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] c_aluLui   = ALUOP_W'(12);
`ifdef MIPS_CTRL_MDU_EN
  localparam logic [ALUOP_W-1:0] c_aluMult  = ALUOP_W'(13);
  localparam logic [ALUOP_W-1:0] c_aluMultu = ALUOP_W'(14);
  localparam logic [ALUOP_W-1:0] c_aluDiv   = ALUOP_W'(15);
  localparam logic [ALUOP_W-1:0] c_aluDivu  = ALUOP_W'(16);
  localparam logic [ALUOP_W-1:0] c_aluMfhi  = ALUOP_W'(17);
  localparam logic [ALUOP_W-1:0] c_aluMflo  = ALUOP_W'(18);
`endif

  typedef struct packed {
    logic [ALUOP_W-1:0] aluOp;
    logic               aluSrc;
    logic               link;
    logic [4:0]         dst;
    logic               memRead;
    logic               memWrite;
    logic               memByte;
    logic               memHalf;
    logic               memSignExt;
    logic               regWrite;
    logic               memToReg;
  } ctrl_t;

  ctrl_t      w_dec;
  ctrl_t      r_ex;
  logic       w_known;
  logic       w_wr;
  logic [4:0] w_dstSel;
  logic       w_readsRt;
  logic       w_isBeq;
  logic       w_isBne;
  logic       w_isJ;
  logic       w_isJal;
  logic       w_isJr;
  logic       w_isMduOp;
  logic       w_isMduAny;

  logic       r_memRead;
  logic       r_memWrite;
  logic       r_memByte;
  logic       r_memHalf;
  logic       r_memSignExt;
  logic       r_memRegWrite;
  logic       r_memMemToReg;
  logic [4:0] r_memDst;
  logic       r_wbRegWrite;
  logic       r_wbMemToReg;
  logic [4:0] r_wbDst;

  logic       w_isBranch;
  logic       w_exLoadHit;
  logic       w_brExHit;
  logic       w_brMemHit;
  logic       w_mduHaz;
  logic       w_stall;

  always_comb begin
    w_dec      = '0;
    w_known    = 1'b0;
    w_wr       = 1'b0;
    w_dstSel   = 5'd0;
    w_readsRt  = 1'b0;
    w_isBeq    = 1'b0;
    w_isBne    = 1'b0;
    w_isJ      = 1'b0;
    w_isJal    = 1'b0;
    w_isJr     = 1'b0;
    w_isMduOp  = 1'b0;
    w_isMduAny = 1'b0;
    case (OpCode)
      6'h00: begin
        w_readsRt = 1'b1;
        w_dstSel  = id_rd;
        case (Func)
          6'h20: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluAdd;  end
          6'h21: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluAddu; end
          6'h22: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluSub;  end
          6'h23: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluSubu; end
          6'h24: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluAnd;  end
          6'h25: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluOr;   end
          6'h26: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluXor;  end
          6'h27: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluNor;  end
          6'h2A: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluSlt;  end
          6'h2B: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluSltu; end
          6'h00: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluSll;  end
          6'h02: begin w_known = 1'b1; w_wr = 1'b1; w_dec.aluOp = c_aluSrl;  end
          6'h08: begin w_known = 1'b1; w_isJr = 1'b1; end
`ifdef MIPS_CTRL_MDU_EN
          6'h18: begin w_known = 1'b1; w_isMduOp = 1'b1; w_dec.aluOp = c_aluMult;  end
          6'h19: begin w_known = 1'b1; w_isMduOp = 1'b1; w_dec.aluOp = c_aluMultu; end
          6'h1A: begin w_known = 1'b1; w_isMduOp = 1'b1; w_dec.aluOp = c_aluDiv;   end
          6'h1B: begin w_known = 1'b1; w_isMduOp = 1'b1; w_dec.aluOp = c_aluDivu;  end
          6'h10: begin w_known = 1'b1; w_wr = 1'b1; w_isMduAny = 1'b1; w_dec.aluOp = c_aluMfhi; end
          6'h12: begin w_known = 1'b1; w_wr = 1'b1; w_isMduAny = 1'b1; w_dec.aluOp = c_aluMflo; end
`endif
          default: ;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        w_known       = 1'b1;
        w_wr          = 1'b1;
        w_dstSel      = id_rt;
        w_dec.aluSrc  = 1'b1;
        case (OpCode[2:0])
          3'd0:    w_dec.aluOp = c_aluAdd;
          3'd1:    w_dec.aluOp = c_aluAddu;
          3'd2:    w_dec.aluOp = c_aluSlt;
          3'd3:    w_dec.aluOp = c_aluSltu;
          3'd4:    w_dec.aluOp = c_aluAnd;
          3'd5:    w_dec.aluOp = c_aluOr;
          3'd6:    w_dec.aluOp = c_aluXor;
          default: w_dec.aluOp = c_aluLui;
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        w_known          = 1'b1;
        w_wr             = 1'b1;
        w_dstSel         = id_rt;
        w_dec.aluSrc     = 1'b1;
        w_dec.aluOp      = c_aluAddu;
        w_dec.memRead    = 1'b1;
        w_dec.memToReg   = 1'b1;
        w_dec.memByte    = (OpCode[1:0] == 2'd0);
        w_dec.memHalf    = (OpCode[1:0] == 2'd1);
        w_dec.memSignExt = (OpCode == 6'h20) || (OpCode == 6'h21);
      end
      6'h28, 6'h29, 6'h2B: begin
        w_known        = 1'b1;
        w_readsRt      = 1'b1;
        w_dec.aluSrc   = 1'b1;
        w_dec.aluOp    = c_aluAddu;
        w_dec.memWrite = 1'b1;
        w_dec.memByte  = (OpCode == 6'h28);
        w_dec.memHalf  = (OpCode == 6'h29);
      end
      6'h04: begin w_known = 1'b1; w_readsRt = 1'b1; w_isBeq = 1'b1; end
      6'h05: begin w_known = 1'b1; w_readsRt = 1'b1; w_isBne = 1'b1; end
      6'h02: begin w_known = 1'b1; w_isJ = 1'b1; end
      6'h03: begin
        w_known    = 1'b1;
        w_isJal    = 1'b1;
        w_wr       = 1'b1;
        w_dstSel   = 5'd31;
        w_dec.link = 1'b1;
      end
      default: ;
    endcase
    // Anything not both valid and recognised collapses to the all-zero bubble.
    if (id_valid && w_known) begin
      w_dec.dst      = w_wr ? w_dstSel : 5'd0;
      w_dec.regWrite = w_wr && (w_dstSel != 5'd0);
    end else begin
      w_dec      = '0;
      w_readsRt  = 1'b0;
      w_isBeq    = 1'b0;
      w_isBne    = 1'b0;
      w_isJ      = 1'b0;
      w_isJal    = 1'b0;
      w_isJr     = 1'b0;
      w_isMduOp  = 1'b0;
      w_isMduAny = 1'b0;
    end
    w_isMduAny = w_isMduAny | w_isMduOp;
  end

  // Branch compare and JR target both read registers in ID, so they need the value there.
  assign w_isBranch  = w_isBeq | w_isBne;
  assign w_exLoadHit = r_ex.memRead && (r_ex.dst != 5'd0) &&
                       ((r_ex.dst == id_rs) || (w_readsRt && (r_ex.dst == id_rt)));
  assign w_brExHit   = (w_isBranch || w_isJr) && r_ex.regWrite &&
                       ((r_ex.dst == id_rs) || (w_isBranch && (r_ex.dst == id_rt)));
  assign w_brMemHit  = (w_isBranch || w_isJr) && r_memRead && (r_memDst != 5'd0) &&
                       ((r_memDst == id_rs) || (w_isBranch && (r_memDst == id_rt)));
  assign w_mduHaz    = w_isMduAny && mdu_busy;
  assign w_stall     = id_valid && (w_exLoadHit || w_brExHit || w_brMemHit || w_mduHaz);

  always_comb begin
    PCSrcSel    = 2'b00;
    NextIsDelay = 1'b0;
    if (id_valid && !w_stall) begin
      NextIsDelay = w_isBranch | w_isJ | w_isJal | w_isJr;
      if ((w_isBeq && Comp_EQ) || (w_isBne && !Comp_EQ)) PCSrcSel = 2'b10;
      else if (w_isJ || w_isJal)                          PCSrcSel = 2'b01;
      else if (w_isJr)                                    PCSrcSel = 2'b11;
    end
  end

  assign id_stall = w_stall;
  assign SignExt  = (OpCode[5:2] != 4'b0011);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex          <= '0;
      r_memRead     <= 1'b0;
      r_memWrite    <= 1'b0;
      r_memByte     <= 1'b0;
      r_memHalf     <= 1'b0;
      r_memSignExt  <= 1'b0;
      r_memRegWrite <= 1'b0;
      r_memMemToReg <= 1'b0;
      r_memDst      <= 5'd0;
      r_wbRegWrite  <= 1'b0;
      r_wbMemToReg  <= 1'b0;
      r_wbDst       <= 5'd0;
    end else begin
      r_ex          <= w_stall ? '0 : w_dec;
      r_memRead     <= r_ex.memRead;
      r_memWrite    <= r_ex.memWrite;
      r_memByte     <= r_ex.memByte;
      r_memHalf     <= r_ex.memHalf;
      r_memSignExt  <= r_ex.memSignExt;
      r_memRegWrite <= r_ex.regWrite;
      r_memMemToReg <= r_ex.memToReg;
      r_memDst      <= r_ex.dst;
      r_wbRegWrite  <= r_memRegWrite;
      r_wbMemToReg  <= r_memMemToReg;
      r_wbDst       <= r_memDst;
    end
  end

`ifdef MIPS_CTRL_MDU_EN
  localparam int c_cntW = $clog2(MDU_LATENCY + 1);
  logic [c_cntW-1:0] r_mduCnt;

  always_ff @(posedge clock) begin
    if (reset)                      r_mduCnt <= '0;
    else if (w_isMduOp && !w_stall) r_mduCnt <= c_cntW'(MDU_LATENCY);
    else if (r_mduCnt != '0)        r_mduCnt <= r_mduCnt - c_cntW'(1);
  end

  assign mdu_busy = (r_mduCnt != '0);
`else
  assign mdu_busy = 1'b0;
`endif

  assign ex_alu_op     = r_ex.aluOp;
  assign ex_alu_src    = r_ex.aluSrc;
  assign ex_link       = r_ex.link;
  assign ex_dst        = r_ex.dst;
  assign mem_read      = r_memRead;
  assign mem_write     = r_memWrite;
  assign mem_byte      = r_memByte;
  assign mem_half      = r_memHalf;
  assign mem_sign_ext  = r_memSignExt;
  assign wb_reg_write  = r_wbRegWrite;
  assign wb_mem_to_reg = r_wbMemToReg;
  assign wb_dst        = r_wbDst;

endmodule
`default_nettype wire
